// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine control blocks.
//   dispense_state_t    : dispense controller state encoding (2'b11 unused/illegal)
//   DISPENSE_CYCLES_DEF : default dispense pulse width in clock cycles
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    DISPENSE     = 2'b01,
    WAIT_RELEASE = 2'b10
  } dispense_state_t;

  localparam int DISPENSE_CYCLES_DEF = 2;

endpackage

// File: rtl/ex33_dispense_ctrl.sv
// Dispense actuator controller. Issues one DISPENSE_CYCLES-wide pulse per paid
// request, then waits for the request to drop before it can vend again.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset (IDLE, dispense=0, counter=0)
//   dispense_req : level request to vend
//   payment_ok   : level flag, payment sufficient
//   dispense     : registered Moore actuator drive, high only in DISPENSE
module ex33_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int DISPENSE_CYCLES = DISPENSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dispense_req,
  input  logic payment_ok,
  output logic dispense
);

  localparam int CLOG = $clog2(DISPENSE_CYCLES + 1);
  localparam int CW   = (CLOG < 1) ? 1 : CLOG;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DISPENSE_CYCLES - 1);

  dispense_state_t r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_dispense;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dispense <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      // Output registered from the next state so it tracks DISPENSE exactly
      // with no input-to-output combinational path.
      r_dispense <= (w_state_nxt == DISPENSE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (dispense_req && payment_ok) begin
          w_state_nxt = DISPENSE;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      DISPENSE: begin
        // Counter holds remaining extra cycles; zero means this is the last one.
        if (r_cnt == '0) w_state_nxt = WAIT_RELEASE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      WAIT_RELEASE: begin
        if (!dispense_req) w_state_nxt = IDLE;
      end
      default: begin
        // Illegal 2'b11 recovers to IDLE.
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign dispense = r_dispense;

endmodule

// File: tb/tb_ex33_dispense_ctrl.sv
module tb_ex33_dispense_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic ok  = 1'b0;
  logic [2:0] dsp;

  int checks = 0;
  int errors = 0;

  // Instance widths: index 0 = default (2), 1 = one cycle, 2 = five cycles.
  int ncyc [3] = '{2, 1, 5};
  int rem  [3];
  bit blk  [3];

  always #5 clk = ~clk;

  ex33_dispense_ctrl u_dut_def (
    .clk(clk), .rst(rst), .dispense_req(req), .payment_ok(ok), .dispense(dsp[0]));
  ex33_dispense_ctrl #(.DISPENSE_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .dispense_req(req), .payment_ok(ok), .dispense(dsp[1]));
  ex33_dispense_ctrl #(.DISPENSE_CYCLES(5)) u_dut_w5 (
    .clk(clk), .rst(rst), .dispense_req(req), .payment_ok(ok), .dispense(dsp[2]));

  // Reference: remaining pulse cycles plus a "must release first" flag.
  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      blk[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge(bit r, bit p);
    for (int k = 0; k < 3; k++) begin
      if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) blk[k] = 1'b1;
      end else if (blk[k]) begin
        if (!r) blk[k] = 1'b0;
      end else if (r && p) begin
        rem[k] = ncyc[k];
      end
    end
  endfunction

  function automatic logic [2:0] model_out();
    logic [2:0] e;
    for (int k = 0; k < 3; k++) e[k] = (rem[k] > 0);
    return e;
  endfunction

  task automatic step(input bit r, input bit p);
    req = r;
    ok  = p;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(r, p);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if (dsp !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got %b want 000", dsp);
    end
    rst = 1'b0;
    step(1'b1, 1'b1);
    checks++;
    if (dsp !== 3'b111) begin
      errors++;
      $display("FAIL first_edge_vend: got %b want 111", dsp);
    end
  endtask

  task automatic test_hold_no_revend();
    logic [2:0] e;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1);
      e = model_out();
      checks++;
      if (dsp !== e) begin
        errors++;
        $display("FAIL hold_no_revend cyc%0d: got %b want %b", c, dsp, e);
      end
    end
    step(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b1);
      e = model_out();
      checks++;
      if (dsp !== e) begin
        errors++;
        $display("FAIL revend_after_release cyc%0d: got %b want %b", c, dsp, e);
      end
    end
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
  endtask

  task automatic test_no_payment();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dsp !== 3'b000) begin
        errors++;
        $display("FAIL req_no_pay cyc%0d: got %b want 000", c, dsp);
      end
    end
    step(1'b0, 1'b1);
    checks++;
    if (dsp !== 3'b000) begin
      errors++;
      $display("FAIL pay_no_req: got %b want 000", dsp);
    end
    step(1'b1, 1'b1);
    checks++;
    if (dsp !== 3'b111) begin
      errors++;
      $display("FAIL pay_then_vend: got %b want 111", dsp);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
  endtask

  task automatic test_abort_ignored();
    logic [2:0] e;
    step(1'b1, 1'b1);
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 1'b0);
      e = model_out();
      checks++;
      if (dsp !== e) begin
        errors++;
        $display("FAIL abort_ignored cyc%0d: got %b want %b", c, dsp, e);
      end
    end
  endtask

  task automatic test_pulse_width();
    int cnt [3];
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) if (dsp[k] === 1'b1) cnt[k]++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt[k] != ncyc[k]) begin
        errors++;
        $display("FAIL pulse_width inst%0d: got %0d want %0d", k, cnt[k], ncyc[k]);
      end
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dsp !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_drop: got %b want 000", dsp);
    end
    step(1'b0, 1'b0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0);
      checks++;
      if (dsp !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle cyc%0d: got %b want 000", c, dsp);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] e;
    bit r, p;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 2) != 0);
      step(r, p);
      e = model_out();
      checks++;
      if (dsp !== e) begin
        errors++;
        $display("FAIL random cyc%0d req=%0b ok=%0b: got %b want %b", c, r, p, dsp, e);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_hold_no_revend();
    test_no_payment();
    test_abort_ignored();
    test_pulse_width();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
